// File: rtl/blink_ctrl_pkg.sv
// Shared constants and FSM encoding for the LED/button controller.
package blink_ctrl_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLong
  } press_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and tick-based debouncer; btn_db is 1 while the button is held.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic BTN_N,
  output logic btn_db
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_MS + 1);

  logic [1:0]      sync_q;
  logic            btn_s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], BTN_N};
  end

  assign btn_s = ~sync_q[1];

  // Accept a new level only after it has differed for DEBOUNCE_MS ticks in a row.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (btn_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_MS)) begin
      db_d  = btn_s;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/blink_ctrl.sv
// LED mode controller (off/on/blink/breathe) with debounced short/long press detection.
module blink_ctrl
  import blink_ctrl_pkg::*;
#(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned TICK_DIV      = 48000,
  parameter int unsigned DEBOUNCE_MS   = 10,
  parameter int unsigned LONG_PRESS_MS = 2000,
  parameter int unsigned BLINK_HALF_MS = 250
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    BTN_N,
  input  logic [2*CHANNELS-1:0]   MODE,
  output logic [CHANNELS-1:0]     LED_N,
  output logic                    RST_N,
  output logic                    BTN_SHORT
);

  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned HoldW  = $clog2(LONG_PRESS_MS + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_HALF_MS);
  localparam logic [PWM_BITS-1:0] DutyMax = '1;

  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_up_q, dir_up_d;
  logic                btn_db;
  press_state_e        state_q;
  logic [HoldW-1:0]    hold_q;
  logic                short_q, rst_n_q;
  logic [CHANNELS-1:0] lit;
  logic [CHANNELS-1:0] led_n_q;

  assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));

  // Next-state for the 1 ms prescaler, blink phase and breathe ramp.
  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    pwm_d       = pwm_q + 1'b1;
    duty_d      = duty_q;
    dir_up_d    = dir_up_q;
    if (tick) begin
      if (blink_cnt_q == BlinkW'(BLINK_HALF_MS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      // Endpoints are held for one tick: the reversing tick only flips direction.
      if (dir_up_q) begin
        if (duty_q == DutyMax) dir_up_d = 1'b0;
        else                   duty_d   = duty_q + 1'b1;
      end else begin
        if (duty_q == '0) dir_up_d = 1'b1;
        else              duty_d   = duty_q - 1'b1;
      end
    end
  end

  // Shared timebase registers; never restarted by MODE changes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pwm_q       <= '0;
      duty_q      <= '0;
      dir_up_q    <= 1'b1;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_q       <= pwm_d;
      duty_q      <= duty_d;
      dir_up_q    <= dir_up_d;
    end
  end

  btn_debounce #(
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_btn_debounce (
    .CLK    (CLK),
    .RST    (RST),
    .tick   (tick),
    .BTN_N  (BTN_N),
    .btn_db (btn_db)
  );

  // Press classifier with registered short-press pulse and bootloader request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      hold_q  <= '0;
      short_q <= 1'b0;
      rst_n_q <= 1'b1;
    end else begin
      short_q <= 1'b0;
      rst_n_q <= (state_q != StLong);
      unique case (state_q)
        StIdle: begin
          if (btn_db) begin
            state_q <= StPressed;
            hold_q  <= '0;
          end
        end
        StPressed: begin
          // Release wins over reaching the long-press threshold.
          if (!btn_db) begin
            state_q <= StIdle;
            short_q <= 1'b1;
          end else if (hold_q == HoldW'(LONG_PRESS_MS)) begin
            state_q <= StLong;
          end else if (tick) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        StLong: begin
          if (!btn_db) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [1:0] ch_mode;
    logic       ch_lit;

    assign ch_mode = MODE[2*ch +: 2];

    // Per-channel mode mux over the shared blink phase and PWM duty.
    always_comb begin
      ch_lit = 1'b0;
      unique case (ch_mode)
        MODE_OFF:     ch_lit = 1'b0;
        MODE_ON:      ch_lit = 1'b1;
        MODE_BLINK:   ch_lit = phase_q;
        MODE_BREATHE: ch_lit = (pwm_q < duty_q);
      endcase
    end

    assign lit[ch] = ch_lit;
  end

  // Registered active-low LED drive; all LEDs lit while a long press is held.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) led_n_q <= '1;
    else     led_n_q <= (state_q == StLong) ? '0 : ~lit;
  end

  assign LED_N     = led_n_q;
  assign RST_N     = rst_n_q;
  assign BTN_SHORT = short_q;

endmodule

// File: tb/tb_blink_ctrl.sv
// Self-checking bench for blink_ctrl with a small timebase.
module tb_blink_ctrl;

  localparam int unsigned CH = 3;
  localparam int unsigned PB = 3;
  localparam int unsigned TD = 4;
  localparam int unsigned DB = 3;
  localparam int unsigned LP = 20;
  localparam int unsigned BH = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_n = 1'b1;
  logic [5:0] mode = 6'b0;
  logic [2:0] led_n;
  logic       rst_n;
  logic       btn_short;

  blink_ctrl #(
    .CHANNELS      (CH),
    .PWM_BITS      (PB),
    .TICK_DIV      (TD),
    .DEBOUNCE_MS   (DB),
    .LONG_PRESS_MS (LP),
    .BLINK_HALF_MS (BH)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .BTN_N     (btn_n),
    .MODE      (mode),
    .LED_N     (led_n),
    .RST_N     (rst_n),
    .BTN_SHORT (btn_short)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  typedef struct packed {
    logic [5:0] mode;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected in [%0d,%0d]", name, v, lo, hi);
    end
  endtask

  // Duty after k ticks: 0..7, 7..0, with each endpoint held one extra tick.
  function automatic int duty_at(input int k);
    int p;
    p = k % 16;
    return (p < 8) ? p : 15 - p;
  endfunction

  // LED_N expected after the edge that ends cycle m, given the mode during cycle m.
  function automatic logic [2:0] exp_led(input logic [5:0] md, input int m);
    logic [2:0] r;
    logic [1:0] cm;
    logic       lit;
    int         k;
    k = m / TD;
    for (int c = 0; c < 3; c++) begin
      cm = md[2*c +: 2];
      case (cm)
        2'b00:   lit = 1'b0;
        2'b01:   lit = 1'b1;
        2'b10:   lit = ((k / BH) % 2) == 1;
        default: lit = (m % 8) < duty_at(k);
      endcase
      r[c] = ~lit;
    end
    return r;
  endfunction

  // Advance one cycle and compare any pending LED expectation.
  task automatic step();
    @(negedge clk);
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      check("led_n", {29'b0, led_n}, {29'b0, e});
    end
  endtask

  task automatic run_model(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_led(mode, cyc));
      step();
      if (rst_n !== 1'b1 || btn_short !== 1'b0) bad++;
    end
    check("model_quiet", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, shorts, low, first, p, r, fall, rise, ledbad, w;

    vecs[0] = '{mode: 6'b000000, exp: 3'b111};
    vecs[1] = '{mode: 6'b010101, exp: 3'b000};
    vecs[2] = '{mode: 6'b000001, exp: 3'b110};
    vecs[3] = '{mode: 6'b000100, exp: 3'b101};
    vecs[4] = '{mode: 6'b010000, exp: 3'b011};
    vecs[5] = '{mode: 6'b010001, exp: 3'b010};

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_led_n", {29'b0, led_n}, 32'h7);
    check("reset_rst_n", {31'b0, rst_n}, 32'h1);
    check("reset_short", {31'b0, btn_short}, 32'h0);
    rst = 1'b0;

    // Static modes, one-cycle latency from MODE to LED_N.
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      exp_q.push_back(vecs[i].exp);
      step();
    end

    // Blink on ch2, on ch1, off ch0; then switch to all-breathe without restarting.
    mode = 6'b100100;
    run_model(100);
    mode = 6'b111111;
    run_model(160);

    // Bounces of two ticks are filtered.
    mode = 6'b000000;
    bad = 0;
    for (int rep = 0; rep < 4; rep++) begin
      btn_n = 1'b0;
      repeat (8) begin step(); if (btn_short !== 1'b0 || rst_n !== 1'b1) bad++; end
      btn_n = 1'b1;
      repeat (8) begin step(); if (btn_short !== 1'b0 || rst_n !== 1'b1) bad++; end
    end
    repeat (30) begin step(); if (btn_short !== 1'b0 || rst_n !== 1'b1) bad++; end
    check("bounce_quiet", bad, 0);

    // Short press: exactly one pulse shortly after release.
    btn_n = 1'b0;
    shorts = 0; low = 0; first = -1;
    repeat (40) begin step(); if (btn_short) shorts++; if (!rst_n) low++; end
    btn_n = 1'b1;
    r = cyc;
    repeat (60) begin
      step();
      if (btn_short) begin shorts++; if (first < 0) first = cyc - r; end
      if (!rst_n) low++;
    end
    check("short_count", shorts, 1);
    check_win("short_delay", first, 11, 18);
    check("short_rst_n", low, 0);

    // Long press: bootloader request with all LEDs lit, no short pulse.
    btn_n = 1'b0;
    p = cyc; fall = -1; shorts = 0; ledbad = 0;
    repeat (120) begin
      step();
      if (!rst_n) begin
        if (fall < 0) fall = cyc - p;
        if (led_n !== 3'b000) ledbad++;
      end
      if (btn_short) shorts++;
    end
    check_win("long_fall", fall, 88, 100);
    check("long_leds", ledbad, 0);
    btn_n = 1'b1;
    r = cyc; rise = -1;
    repeat (40) begin
      step();
      if (rst_n && rise < 0) rise = cyc - r;
      if (btn_short) shorts++;
    end
    check_win("long_rise", rise, 11, 19);
    check("long_no_short", shorts, 0);
    check("long_led_after", {29'b0, led_n}, 32'h7);

    // Asynchronous reset while in LONG.
    btn_n = 1'b0;
    w = 0;
    while (rst_n === 1'b1 && w < 150) begin step(); w++; end
    check("long_reached", {31'b0, rst_n}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_n", {31'b0, rst_n}, 32'h1);
    check("async_led_n", {29'b0, led_n}, 32'h7);
    check("async_short", {31'b0, btn_short}, 32'h0);
    btn_n = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (30) begin step(); if (btn_short !== 1'b0 || rst_n !== 1'b1) bad++; end
    check("post_reset_quiet", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blink_ctrl.md
# blink_ctrl

Parametrised LED and button controller for the OrangeCrab top level. It drives `CHANNELS` active-low LEDs, each in a per-channel selectable mode: off, on, blink, or breathe (triangular PWM). It also debounces `BTN_N` and classifies presses:
- A short press produces a one-cycle event.
- A long press asserts `RST_N` low to enter the bootloader.

## Interface
Parameters:
- `CHANNELS`, 3: number of LED outputs.
- `PWM_BITS`, 8: PWM counter and duty width.
- `TICK_DIV`, 48000: `CLK` cycles per 1 ms tick (48 MHz).
- `DEBOUNCE_MS`, 10: ticks the input must be stable before it is accepted.
- `LONG_PRESS_MS`, 2000: hold time that qualifies as a long press.
- `BLINK_HALF_MS`, 250: blink half-period, in ticks.

Ports:
- `CLK`  in  1  the single clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `BTN_N`  in  1  raw button, active-low, asynchronous to `CLK`.
- `MODE`  in  2*CHANNELS  mode for channel i in bits [2i+1:2i]: 00 off, 01 on, 10 blink, 11 breathe.
- `LED_N`  out  CHANNELS  LED drive, active-low.
- `RST_N`  out  1  bootloader reset request, active-low.
- `BTN_SHORT`  out  1  one-cycle pulse on a qualified short press.

## Operation
- **Reset values:** `LED_N` = all 1, `RST_N` = 1, `BTN_SHORT` = 0.
  - Internal state: tick counter 0; synchroniser 1 (button released); debounced state released; FSM in IDLE; duty 0 with direction up; blink phase 0; PWM counter 0.
- **Tick:** counter runs 0..TICK_DIV-1. The `tick` strobe is high for one cycle when the counter wraps.
- **Synchroniser:** 2-flop on `BTN_N`, then inverted to give `btn_s` (1 = pressed).
- **Debounce:**
  - `btn_db` holds the accepted level.
  - While `btn_s` != `btn_db`, a counter increments on each tick.
  - When the counter reaches `DEBOUNCE_MS`, `btn_db` takes `btn_s` and the counter clears.
  - Any cycle with `btn_s` == `btn_db` clears the counter, so bounces shorter than `DEBOUNCE_MS` are ignored.
- **Press FSM (IDLE, PRESSED, LONG):**
  - IDLE -> PRESSED on `btn_db` rising; the hold counter clears.
  - PRESSED: the hold counter increments on each tick.
    - If `btn_db` falls, the FSM returns to IDLE and `BTN_SHORT` = 1 for one cycle.
    - Else, if the hold counter reaches `LONG_PRESS_MS`, the FSM moves to LONG.
    - Release takes priority when it coincides with the threshold.
  - LONG: `RST_N` = 0, and all `LED_N` = 0 as user feedback. The FSM returns to IDLE on `btn_db` falling, with no `BTN_SHORT` pulse.
  - Each press yields exactly one event.
- **Blink:** a shared phase bit toggles every `BLINK_HALF_MS` ticks. A channel in blink mode is lit when the phase is 1.
- **Breathe:**
  - A free-running `PWM_BITS` counter runs at `CLK` rate.
  - Shared duty steps by ±1 per tick. Direction reverses at 2^PWM_BITS-1 and at 0; the endpoint value is held for exactly one tick before the reversal.
  - A channel is lit when the PWM counter < duty, so duty 0 means fully dark.
- **Shared timebase:** all channels share the phase and duty. A `MODE` change never restarts either, so channels in the same mode stay in lockstep.

## Timing
- `LED_N` is registered: one-cycle latency from `MODE` or internal state to the pin.
- `BTN_N` edge to `btn_db` change: 2 cycles of synchronisation plus `DEBOUNCE_MS` ticks, with ±1 tick of quantisation.
- `RST_N` falls in the cycle after the FSM enters LONG (registered). It rises in the cycle after leaving LONG, or immediately on `RST`.
- `BTN_SHORT` is registered and is never high for more than one cycle.
- Asserting `RST` mid-operation (including during LONG) returns all outputs to their reset values asynchronously.
- Counter widths are `$clog2(max+1)` of the respective limit. No counter may wrap past its limit.

## Structure
- Package `blink_ctrl_pkg` holds:
  - Mode constants `MODE_OFF`, `MODE_ON`, `MODE_BLINK`, `MODE_BREATHE`.
  - FSM state encoding (IDLE, PRESSED, LONG).
- Sub-module `btn_debounce` contains the synchroniser and debounce counter. Inputs: `CLK`, `RST`, `tick`, `BTN_N`. Output: `btn_db`.
- Top level contains the tick prescaler, press FSM, blink/breathe generators and the per-channel output mux in a generate loop.

## Test plan
Bench parameters: `TICK_DIV`=4, `DEBOUNCE_MS`=3, `LONG_PRESS_MS`=20, `BLINK_HALF_MS`=5, `PWM_BITS`=3, `CHANNELS`=3.
- Reset, `MODE`=0b10_01_00 -> `LED_N`[0]=1 constant; `LED_N`[1]=0 constant; `LED_N`[2] toggles every 20 cycles. `RST_N`=1 and `BTN_SHORT`=0 throughout.
- `BTN_N` low pulses of 2 ticks (8 cycles), separated by highs -> no `BTN_SHORT` and no state change.
- `BTN_N` low for 40 cycles, then high -> exactly one `BTN_SHORT` pulse about 14 cycles after the release; `RST_N` stays 1.
- `BTN_N` low for 120 cycles -> `RST_N`=0 about 94 cycles after the press, with all `LED_N`=0. After release, `RST_N`=1 and no `BTN_SHORT` pulse.
- Assert `RST` while in LONG -> `RST_N`=1 and `LED_N`=all 1 without waiting for a clock edge.
- `MODE`=all breathe -> duty ramps 0..7..0 over 16 ticks. Lit cycles per 8-cycle PWM period equal the duty value, and all three channels are identical.
